// File: rtl/err_compute_pipe.sv
// Weighted right/left IR error: captures NUM_PAIRS readings, accumulates one
// shifted term per cycle, then presents a saturated signed result with a pulse.
module err_compute_pipe #(
    parameter int NUM_PAIRS  = 4,
    parameter int DATA_W     = 12,
    parameter int SHIFT_STEP = 1,
    parameter int ERR_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          IR_vld,
    input  logic [NUM_PAIRS*DATA_W-1:0]   IR_R,
    input  logic [NUM_PAIRS*DATA_W-1:0]   IR_L,
    input  logic                          clr_ovr,
    output logic signed [ERR_W-1:0]       error,
    output logic                          err_vld,
    output logic                          sat,
    output logic                          busy,
    output logic                          overrun
);
    localparam int ACC_W = DATA_W + (NUM_PAIRS-1)*SHIFT_STEP + $clog2(NUM_PAIRS) + 2;
    localparam int IDX_W = $clog2(2*NUM_PAIRS);
    localparam int CMP_W = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*NUM_PAIRS-1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    localparam logic signed [CMP_W-1:0] MAXV = {{(CMP_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] MINV = {{(CMP_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

    logic [1:0]                    r_state;
    logic [IDX_W-1:0]              r_idx;
    logic signed [ACC_W-1:0]       r_acc;
    logic [NUM_PAIRS*DATA_W-1:0]   r_cap_r, r_cap_l;
    logic signed [ERR_W-1:0]       r_error;
    logic                          r_err_vld, r_sat, r_ovr;

    logic [IDX_W-1:0]              w_pair;
    logic [DATA_W-1:0]             w_sel;
    logic [ACC_W-1:0]              w_term;
    logic signed [CMP_W-1:0]       w_acc_x;
    logic                          w_hi, w_lo;
    logic signed [ERR_W-1:0]       w_sat_val;

    // Even index adds a right reading, odd index subtracts the matching left one
    assign w_pair  = r_idx >> 1;
    assign w_sel   = r_idx[0] ? r_cap_l[w_pair*DATA_W +: DATA_W]
                              : r_cap_r[w_pair*DATA_W +: DATA_W];
    assign w_term  = ACC_W'(w_sel) << (w_pair*SHIFT_STEP);

    assign w_acc_x   = r_acc;
    assign w_hi      = (w_acc_x > MAXV);
    assign w_lo      = (w_acc_x < MINV);
    assign w_sat_val = w_hi ? MAXV[ERR_W-1:0] : (w_lo ? MINV[ERR_W-1:0] : w_acc_x[ERR_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_cap_r   <= '0;
            r_cap_l   <= '0;
            r_error   <= '0;
            r_err_vld <= 1'b0;
            r_sat     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_err_vld <= 1'b0;
            // A strobe arriving while busy is dropped but remembered; it beats a clear
            if (IR_vld && (r_state != S_IDLE))
                r_ovr <= 1'b1;
            else if (clr_ovr)
                r_ovr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (IR_vld) begin
                        r_cap_r <= IR_R;
                        r_cap_l <= IR_L;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_idx[0] ? (r_acc - $signed(w_term)) : (r_acc + $signed(w_term));
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX)
                        r_state <= S_OUT;
                end
                S_OUT: begin
                    r_error   <= w_sat_val;
                    r_sat     <= w_hi | w_lo;
                    r_err_vld <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign error   = r_error;
    assign err_vld = r_err_vld;
    assign sat     = r_sat;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_ovr;
endmodule

// File: tb/tb_err_compute_pipe.sv
// Directed bench for err_compute_pipe: latency, sign, saturation, capture,
// overrun, mid-run reset and back-to-back acceptance.
module tb_err_compute_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        IR_vld;
    logic [47:0] IR_R, IR_L;
    logic        clr_ovr;
    logic signed [15:0] error_a;
    logic        err_vld_a, sat_a, busy_a, overrun_a;
    logic signed [13:0] error_b;
    logic        err_vld_b, sat_b, busy_b, overrun_b;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    err_compute_pipe #(.NUM_PAIRS(4), .DATA_W(12), .SHIFT_STEP(1), .ERR_W(16)) dut_a (
        .clk(clk), .rst(rst), .IR_vld(IR_vld), .IR_R(IR_R), .IR_L(IR_L), .clr_ovr(clr_ovr),
        .error(error_a), .err_vld(err_vld_a), .sat(sat_a), .busy(busy_a), .overrun(overrun_a));

    err_compute_pipe #(.NUM_PAIRS(4), .DATA_W(12), .SHIFT_STEP(1), .ERR_W(14)) dut_b (
        .clk(clk), .rst(rst), .IR_vld(IR_vld), .IR_R(IR_R), .IR_L(IR_L), .clr_ovr(clr_ovr),
        .error(error_b), .err_vld(err_vld_b), .sat(sat_b), .busy(busy_b), .overrun(overrun_b));

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pk(input int p0, input int p1, input int p2, input int p3);
        logic [11:0] a, b, c, d;
        a = p0[11:0]; b = p1[11:0]; c = p2[11:0]; d = p3[11:0];
        return {d, c, b, a};
    endfunction

    // Called #1 after an edge; strobe is sampled at the next edge (edge k)
    task automatic start(input logic [47:0] r, input logic [47:0] l);
        IR_R = r; IR_L = l; IR_vld = 1'b1;
        @(posedge clk); #1;
        IR_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!err_vld_a && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, n, exp_lat);
    endtask

    task automatic count_pulses(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (err_vld_a) c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; IR_vld = 1'b0; IR_R = '0; IR_L = '0; clr_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_error", int'(error_a), 0);
        chk("rst_err_vld", int'(err_vld_a), 0);
        chk("rst_sat", int'(sat_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_overrun", int'(overrun_a), 0);
        chk("rst_b", int'({err_vld_b, sat_b, busy_b, overrun_b}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single term, latency 9 edges
        start(pk(100, 0, 0, 0), pk(0, 0, 0, 0));
        chk("busy_after_capture", int'(busy_a), 1);
        wait_done("lat_r0", 9);
        chk("r0_error", int'(error_a), 100);
        chk("r0_sat", int'(sat_a), 0);
        chk("r0_busy_low", int'(busy_a), 0);
        @(posedge clk); #1;
        chk("r0_pulse_one_cycle", int'(err_vld_a), 0);
        chk("r0_error_held", int'(error_a), 100);

        // weighted difference and its negation
        start(pk(10, 20, 30, 40), pk(40, 30, 20, 10));
        wait_done("lat_mix", 9);
        chk("mix_error", int'(error_a), 230);
        start(pk(40, 30, 20, 10), pk(10, 20, 30, 40));
        wait_done("lat_swap", 9);
        chk("swap_error", int'(error_a), -230);
        chk("swap_sat", int'(sat_a), 0);

        // saturation both directions
        start(pk(4095, 4095, 4095, 4095), pk(0, 0, 0, 0));
        wait_done("lat_satp", 9);
        chk("satp_error", int'(error_a), 32767);
        chk("satp_sat", int'(sat_a), 1);
        start(pk(0, 0, 0, 0), pk(4095, 4095, 4095, 4095));
        wait_done("lat_satn", 9);
        chk("satn_error", int'(error_a), -32768);
        chk("satn_sat", int'(sat_a), 1);

        // R3 alone: fits 16 bits, clips 14 bits
        start(pk(0, 0, 0, 4095), pk(0, 0, 0, 0));
        wait_done("lat_r3", 9);
        chk("r3_error16", int'(error_a), 32760);
        chk("r3_sat16", int'(sat_a), 0);
        chk("r3_vld14", int'(err_vld_b), 1);
        chk("r3_error14", int'(error_b), 8191);
        chk("r3_sat14", int'(sat_b), 1);

        // inputs churn after capture; strobes while busy only set overrun
        start(pk(1, 2, 3, 4), pk(0, 0, 0, 0));
        for (int i = 1; i <= 8; i++) begin
            IR_R = {$urandom, $urandom};
            IR_L = {$urandom, $urandom};
            IR_vld  = (i == 4) || (i == 6);
            clr_ovr = (i == 6);
            @(posedge clk); #1;
            IR_vld = 1'b0; clr_ovr = 1'b0;
            if (i == 4) chk("ovr_set", int'(overrun_a), 1);
            if (i == 6) chk("ovr_set_beats_clr", int'(overrun_a), 1);
        end
        wait_done("lat_capture", 1);
        chk("capture_error", int'(error_a), 49);
        count_pulses(12, c);
        chk("no_second_vld", c, 0);
        chk("ovr_sticky", int'(overrun_a), 1);
        clr_ovr = 1'b1;
        @(posedge clk); #1;
        clr_ovr = 1'b0;
        chk("ovr_cleared", int'(overrun_a), 0);

        // reset mid-computation
        start(pk(7, 7, 7, 7), pk(0, 0, 0, 0));
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_error", int'(error_a), 0);
        chk("midrst_busy", int'(busy_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_pulses(12, c);
        chk("midrst_no_vld", c, 0);
        start(pk(100, 0, 0, 0), pk(0, 0, 0, 0));
        wait_done("lat_after_rst", 9);
        chk("after_rst_error", int'(error_a), 100);

        // back-to-back: next strobe in the err_vld cycle
        @(posedge clk); #1;
        start(pk(10, 20, 30, 40), pk(40, 30, 20, 10));
        wait_done("lat_b2b_first", 9);
        chk("b2b_first", int'(error_a), 230);
        start(pk(40, 30, 20, 10), pk(10, 20, 30, 40));
        chk("b2b_no_ovr", int'(overrun_a), 0);
        wait_done("lat_b2b_second", 9);
        chk("b2b_second", int'(error_a), -230);
        chk("b2b_ovr_end", int'(overrun_a), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
